reset_seq: RTL and testbench

Reset sequencer for the pipeline CPU. It takes the debounced button-reset level and a soft-reset request from the debug side. It releases the design's reset domains in a fixed order: clock-division unit first, then memory initialisation with a start/done handshake, then the pipeline. It also runs soft resets of the pipeline and memory without disturbing the clock divider. It sits between the reset debouncer and the clock-division unit, memory-init engine and pipeline core.

---
 rtl/reset_seq.sv | 176 +++++++++++++++++
 tb/tb_reset_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// reset_seq: reset sequencer for the pipeline CPU.
// Releases reset domains in order (clock divider, memory init, pipeline),
// then runs the CPU. It also performs soft resets of memory and pipeline
// while the divider stays out of reset.
// Ports:
//   clk            system clock
//   reset          async active-high global reset
//   rst_req        debounced button-reset level (sync to clk)
//   soft_req       soft-reset request level, held until soft_ack
//   mem_init_done  memory-init completion (level or pulse)
//   div_rst        clock-division unit reset
//   pipe_rst       pipeline reset
//   mem_init_start one-cycle start pulse to the memory-init engine
//   cpu_run        high only in RUN
//   soft_ack       one-cycle acknowledge when a soft reset completes
//   init_err       sticky memory-init timeout flag
//   state          current state encoding (debug)
module reset_seq #(
  parameter int unsigned DIV_HOLD   = 16,
  parameter int unsigned MEM_TO     = 256,
  parameter int unsigned PIPE_DELAY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_req,
  input  logic       soft_req,
  input  logic       mem_init_done,
  output logic       div_rst,
  output logic       pipe_rst,
  output logic       mem_init_start,
  output logic       cpu_run,
  output logic       soft_ack,
  output logic       init_err,
  output logic [2:0] state
);

  localparam int unsigned MAX_A   = (DIV_HOLD > MEM_TO) ? DIV_HOLD : MEM_TO;
  localparam int unsigned CNT_MAX = (MAX_A > PIPE_DELAY) ? MAX_A : PIPE_DELAY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_DIV  = 3'd1,
    ST_MEM  = 3'd2,
    ST_PIPE = 3'd3,
    ST_RUN  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_active_q, soft_active_d;
  logic             armed_q, armed_d;
  logic             div_rst_q, div_rst_d;
  logic             pipe_rst_q, pipe_rst_d;
  logic             start_q, start_d;
  logic             cpu_run_q, cpu_run_d;
  logic             soft_ack_q, soft_ack_d;
  logic             init_err_q, init_err_d;
  logic             mem_timeout;
  logic             soft_go;

  // State, counter, flag and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HOLD;
      cnt_q         <= '0;
      soft_active_q <= 1'b0;
      armed_q       <= 1'b0;
      div_rst_q     <= 1'b1;
      pipe_rst_q    <= 1'b1;
      start_q       <= 1'b0;
      cpu_run_q     <= 1'b0;
      soft_ack_q    <= 1'b0;
      init_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      soft_active_q <= soft_active_d;
      armed_q       <= armed_d;
      div_rst_q     <= div_rst_d;
      pipe_rst_q    <= pipe_rst_d;
      start_q       <= start_d;
      cpu_run_q     <= cpu_run_d;
      soft_ack_q    <= soft_ack_d;
      init_err_q    <= init_err_d;
    end
  end

  // Next-state and phase counter
  always_comb begin
    state_d     = state_q;
    mem_timeout = 1'b0;
    soft_go     = 1'b0;
    if (rst_req) begin
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: state_d = ST_DIV;
        ST_DIV: begin
          if (cnt_q == CNT_W'(DIV_HOLD - 1)) state_d = ST_MEM;
        end
        ST_MEM: begin
          // cnt_q is zero only in the first MEM cycle, where done is ignored
          if ((cnt_q != '0) && mem_init_done) begin
            state_d = ST_PIPE;
          end else if (cnt_q == CNT_W'(MEM_TO - 1)) begin
            state_d     = ST_PIPE;
            mem_timeout = 1'b1;
          end
        end
        ST_PIPE: begin
          if (cnt_q == CNT_W'(PIPE_DELAY - 1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (soft_req && armed_q) begin
            state_d = ST_MEM;
            soft_go = 1'b1;
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end

    // Cleared on every state change, saturating otherwise
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(CNT_MAX)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs and soft-reset flags, decoded from the next state
  always_comb begin
    div_rst_d     = (state_d == ST_HOLD);
    pipe_rst_d    = (state_d != ST_RUN);
    cpu_run_d     = (state_d == ST_RUN);
    start_d       = (state_d == ST_MEM) && (state_q != ST_MEM);
    soft_ack_d    = (state_d == ST_RUN) && (state_q != ST_RUN) && soft_active_q;

    soft_active_d = soft_active_q;
    if (state_d == ST_HOLD) begin
      soft_active_d = 1'b0;
    end else if (soft_go) begin
      soft_active_d = 1'b1;
    end else if (soft_ack_d) begin
      soft_active_d = 1'b0;
    end

    // Re-arm only after the request has been seen low, so a held level
    // never triggers twice
    armed_d = armed_q;
    if (soft_ack_d) begin
      armed_d = 1'b0;
    end else if (!soft_req) begin
      armed_d = 1'b1;
    end

    init_err_d = init_err_q;
    if (state_d == ST_HOLD) begin
      init_err_d = 1'b0;
    end else if (mem_timeout) begin
      init_err_d = 1'b1;
    end
  end

  assign div_rst        = div_rst_q;
  assign pipe_rst       = pipe_rst_q;
  assign mem_init_start = start_q;
  assign cpu_run        = cpu_run_q;
  assign soft_ack       = soft_ack_q;
  assign init_err       = init_err_q;
  assign state          = state_q;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: scoreboard bench for reset_seq. Expected output vectors
// are queued per clock edge as stimulus is planned and compared on the
// following falling edge.
module tb_reset_seq;

  localparam int unsigned DH = 16;
  localparam int unsigned TO = 256;
  localparam int unsigned PD = 4;

  logic       clk;
  logic       reset;
  logic       rst_req;
  logic       soft_req;
  logic       mem_init_done;
  logic       div_rst;
  logic       pipe_rst;
  logic       mem_init_start;
  logic       cpu_run;
  logic       soft_ack;
  logic       init_err;
  logic [2:0] state;

  reset_seq #(
    .DIV_HOLD  (DH),
    .MEM_TO    (TO),
    .PIPE_DELAY(PD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rst_req       (rst_req),
    .soft_req      (soft_req),
    .mem_init_done (mem_init_done),
    .div_rst       (div_rst),
    .pipe_rst      (pipe_rst),
    .mem_init_start(mem_init_start),
    .cpu_run       (cpu_run),
    .soft_ack      (soft_ack),
    .init_err      (init_err),
    .state         (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {state, div_rst, pipe_rst, mem_init_start, cpu_run, soft_ack, init_err}
  logic [8:0] obs;
  assign obs = {state, div_rst, pipe_rst, mem_init_start, cpu_run, soft_ack, init_err};

  typedef struct {
    int unsigned cyc;
    string       tag;
    logic [8:0]  exp;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  int unsigned ecnt  = 0;
  int          n_chk = 0;
  int          n_bad = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%b exp=%b (st,div,pipe,start,run,ack,err)",
               tag, ecnt, got, exp);
    end
  endtask

  function automatic logic [8:0] vec(input logic [2:0] st, input logic dv, input logic pp,
                                     input logic stt, input logic rn, input logic ak,
                                     input logic er);
    return {st, dv, pp, stt, rn, ak, er};
  endfunction

  logic [8:0] v_hold, v_div, v_run0;
  assign v_hold = vec(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  assign v_div  = vec(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  assign v_run0 = vec(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

  task automatic push(input int unsigned cyc, input string tag, input logic [8:0] exp);
    sb_t e;
    e.cyc = cyc;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic rng(input int unsigned a, input int unsigned b, input string tag,
                     input logic [8:0] exp);
    for (int unsigned c = a; c <= b; c++) push(c, tag, exp);
  endtask

  // Hard boot: DIV from edge d, done sampled at edge de
  task automatic push_boot(input int unsigned d, input int unsigned de, input logic er);
    rng(d, d + DH - 1, "div", v_div);
    push(d + DH, "mem_start", vec(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    if (de > d + DH + 1)
      rng(d + DH + 1, de - 1, "mem_wait", vec(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rng(de, de + PD - 1, "pipe", vec(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, er));
    push(de + PD, "run_entry", vec(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er));
  endtask

  // Soft reset: MEM from edge s, done sampled at edge de, ack on RUN re-entry
  task automatic push_soft(input int unsigned s, input int unsigned de);
    push(s, "soft_mem_start", vec(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    rng(s + 1, de - 1, "soft_mem_wait", vec(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rng(de, de + PD - 1, "soft_pipe", vec(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    push(de + PD, "soft_ack", vec(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
  endtask

  // Advance to 1 time unit after edge t
  task automatic tick_to(input int unsigned t);
    while (ecnt < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= ecnt) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, obs, mon_e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d got=running exp=finished", ecnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned b, d, de, m, m2, s, s2, h, s3;
    reset         = 1'b0;
    rst_req       = 1'b0;
    soft_req      = 1'b0;
    mem_init_done = 1'b0;
    #1 reset = 1'b1;
    #1 chk("reset_vals", obs, v_hold);
    rng(1, 3, "hold_in_reset", v_hold);
    tick_to(3);
    reset = 1'b0;

    // Cold boot, done pulsed 5 cycles after start
    b = ecnt;
    push_boot(b + 1, b + 22, 1'b0);
    rng(b + 27, b + 29, "run", v_run0);
    tick_to(b + 21); mem_init_done = 1'b1;
    tick_to(b + 22); mem_init_done = 1'b0;
    tick_to(b + 29);

    // Timeout: done never arrives
    b  = ecnt;
    de = b + 2 + DH + TO;
    push(b + 1, "hard_hold", v_hold);
    push_boot(b + 2, de, 1'b1);
    rng(de + PD + 1, de + PD + 3, "err_sticky", vec(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    push(de + PD + 4, "err_clear", v_hold);
    rst_req = 1'b1;
    tick_to(b + 1); rst_req = 1'b0;
    tick_to(de + PD + 3); rst_req = 1'b1;
    tick_to(de + PD + 4); rst_req = 1'b0;

    // Abort in the 3rd MEM cycle, then a full repeat with level done
    d  = ecnt + 1;
    m  = d + DH;
    m2 = m + 4 + DH;
    rng(d, m - 1, "div", v_div);
    push(m, "mem_start", vec(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    rng(m + 1, m + 2, "mem_wait", vec(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    push(m + 3, "abort_hold", v_hold);
    push_boot(m + 4, m2 + 2, 1'b0);
    rng(m2 + 2 + PD + 1, m2 + 2 + PD + 2, "run", v_run0);
    tick_to(m + 2); rst_req = 1'b1;
    tick_to(m + 3); rst_req = 1'b0;
    tick_to(m2);    mem_init_done = 1'b1;
    tick_to(m2 + 2); mem_init_done = 1'b0;
    tick_to(m2 + 2 + PD + 2);

    // Soft reset with held request, then drop and re-raise
    b  = ecnt;
    s  = b + 1;
    s2 = s + 13;
    push_soft(s, s + 2);
    rng(s + PD + 3, s + 12, "held_no_retrig", v_run0);
    push_soft(s2, s2 + 2);
    rng(s2 + PD + 3, s2 + PD + 6, "run", v_run0);
    soft_req = 1'b1;
    tick_to(s + 1);  mem_init_done = 1'b1;
    tick_to(s + 2);  mem_init_done = 1'b0;
    tick_to(s + 11); soft_req = 1'b0;
    tick_to(s + 12); soft_req = 1'b1;
    tick_to(s2 + 1); mem_init_done = 1'b1;
    tick_to(s2 + 2); mem_init_done = 1'b0;
    tick_to(s2 + PD + 4); soft_req = 1'b0;
    tick_to(s2 + PD + 6);

    // Soft and hard on the same edge; held soft serviced once after boot
    b  = ecnt;
    h  = b + 1;
    s3 = h + 25;
    push(h, "hard_wins", v_hold);
    push_boot(h + 1, h + 20, 1'b0);
    push_soft(s3, s3 + 2);
    rng(s3 + PD + 3, s3 + PD + 7, "held_once", v_run0);
    soft_req = 1'b1;
    rst_req  = 1'b1;
    tick_to(h);      rst_req = 1'b0;
    tick_to(h + 19); mem_init_done = 1'b1;
    tick_to(h + 20); mem_init_done = 1'b0;
    tick_to(s3 + 1); mem_init_done = 1'b1;
    tick_to(s3 + 2); mem_init_done = 1'b0;
    tick_to(s3 + PD + 7); soft_req = 1'b0;

    // Async reset between edges while in PIPE
    b = ecnt;
    push(b + 1, "hard_hold", v_hold);
    rng(b + 2, b + 17, "div", v_div);
    push(b + 18, "mem_start", vec(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    push(b + 19, "mem_wait", vec(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    push(b + 20, "pipe", vec(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    push(b + 21, "async_hold", v_hold);
    rng(b + 22, b + 23, "in_reset", v_hold);
    rng(b + 24, b + 25, "div_again", v_div);
    rst_req = 1'b1;
    tick_to(b + 1);  rst_req = 1'b0;
    tick_to(b + 19); mem_init_done = 1'b1;
    tick_to(b + 20); mem_init_done = 1'b0;
    tick_to(b + 21);
    chk("pre_async_pipe", obs, vec(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    #2 reset = 1'b1;
    #1 chk("async_rst_vec", obs, v_hold);
    chk("async_state", {6'd0, state}, 9'd0);
    tick_to(b + 23); reset = 1'b0;
    tick_to(b + 25);
    @(negedge clk);
    #1;
    chk("sb_drain", 9'(sb.size()), 9'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
